// File: rtl/pci_target_burst.sv
// pci_target_burst: 32-bit multiplexed address/data PCI-style memory target.
// A MEM_DEPTH-word memory window at BASE_ADDR serves memory read (0110) and
// memory write (0111) bursts. The first NTRED comes after programmable wait
// states, and the target disconnects with NSTOP at the window end or after
// BURST_MAX transfers.
//
// Ports:
//   clk          bus clock, all state changes on the rising edge
//   reset        synchronous active-low reset
//   Address_Data multiplexed address/data; driven only during read data phases
//   C_BE         command in the address phase, active-low byte enables in data phases
//   NFRAME       active-low frame from the master
//   NIRED        active-low initiator ready
//   NTRED        active-low target ready (registered)
//   NDEVSEL      active-low device select (registered)
//   NSTOP        active-low target stop / disconnect request (registered)
module pci_target_burst #(
    parameter int unsigned MEM_DEPTH   = 16,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFC0,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned BURST_MAX   = 0
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [31:0] Address_Data,
    input  logic [3:0]  C_BE,
    input  logic        NFRAME,
    input  logic        NIRED,
    output logic        NTRED,
    output logic        NDEVSEL,
    output logic        NSTOP
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);
    localparam int unsigned CW = 9;
    localparam int unsigned WW = 3;

    localparam logic [AW-1:0] LAST_IDX = AW'(MEM_DEPTH - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BURST_MAX - 1);
    localparam logic [WW-1:0] WAIT_WR  = WW'(WAIT_STATES);
    // Reads need at least one clock so the master can release the bus.
    localparam logic [WW-1:0] WAIT_RD  = (WAIT_STATES == 0) ? WW'(1) : WW'(WAIT_STATES);

    localparam logic [3:0] CMD_MEM_RD = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_STOPPING,
        S_TURN
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WW-1:0]  wcnt_q, wcnt_d;
    logic           rd_q, rd_d;
    logic           frame_prev_q;
    logic           ntred_q, ntred_d;
    logic           ndevsel_q, ndevsel_d;
    logic           nstop_q, nstop_d;
    logic           oe_q, oe_d;

    logic [31:0]    mem_q [MEM_DEPTH];

    logic           addr_phase_c;
    logic           addr_hit_c;
    logic           xfer_c;
    logic           we_c;
    logic [WW-1:0]  wait_c;

    // Pending transfer is the last one the target will accept in this burst.
    function automatic logic stop_cond(input logic [AW-1:0] idx, input logic [CW-1:0] cnt);
        return (idx == LAST_IDX) || ((BURST_MAX != 0) && (cnt == LAST_CNT));
    endfunction

    // Address phase = NFRAME falling edge; decode the window by its upper address bits.
    assign addr_phase_c = frame_prev_q && !NFRAME;
    assign addr_hit_c   = (Address_Data[31:AW+2] == BASE_ADDR[31:AW+2]) &&
                          ((C_BE == CMD_MEM_RD) || (C_BE == CMD_MEM_WR));
    assign wait_c       = C_BE[0] ? WAIT_WR : WAIT_RD;
    assign xfer_c       = (state_q == S_DATA) && !NIRED;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        rd_d    = rd_q;
        we_c    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (addr_phase_c && addr_hit_c) begin
                    idx_d = Address_Data[AW+1:2];
                    cnt_d = '0;
                    rd_d  = !C_BE[0];
                    if (wait_c == '0) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = wait_c - WW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = S_DATA;
                end else begin
                    wcnt_d = wcnt_q - WW'(1);
                end
            end
            S_DATA: begin
                if (xfer_c) begin
                    we_c = !rd_q;
                    if (NFRAME) begin
                        state_d = S_TURN;
                    end else if (stop_cond(idx_q, cnt_q)) begin
                        state_d = S_STOPPING;
                    end else begin
                        // Only advance while staying in DATA so idx never wraps.
                        idx_d = idx_q + AW'(1);
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_STOPPING: begin
                if (NFRAME) begin
                    state_d = S_TURN;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ntred_d   = !(state_d == S_DATA);
        ndevsel_d = !((state_d == S_WAIT) || (state_d == S_DATA) || (state_d == S_STOPPING));
        nstop_d   = !((state_d == S_STOPPING) ||
                      ((state_d == S_DATA) && stop_cond(idx_d, cnt_d)));
        // Bus drive starts one clock after the address phase (turnaround).
        oe_d      = rd_d && (state_q != S_IDLE) &&
                    ((state_d == S_WAIT) || (state_d == S_DATA));
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            rd_q         <= 1'b0;
            frame_prev_q <= 1'b0;
            ntred_q      <= 1'b1;
            ndevsel_q    <= 1'b1;
            nstop_q      <= 1'b1;
            oe_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            rd_q         <= rd_d;
            frame_prev_q <= NFRAME;
            ntred_q      <= ntred_d;
            ndevsel_q    <= ndevsel_d;
            nstop_q      <= nstop_d;
            oe_q         <= oe_d;
        end
    end

    // Memory window; contents survive reset, writes use active-low byte enables.
    always_ff @(posedge clk) begin
        if (reset && we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (!C_BE[i]) begin
                    mem_q[idx_q][8*i +: 8] <= Address_Data[8*i +: 8];
                end
            end
        end
    end

    assign Address_Data = oe_q ? mem_q[idx_q] : 32'bz;
    assign NTRED        = ntred_q;
    assign NDEVSEL      = ndevsel_q;
    assign NSTOP        = nstop_q;

endmodule

// File: tb/tb_pci_target_burst.sv
// Bench for pci_target_burst: two instances (defaults, and WAIT_STATES=3 /
// BURST_MAX=2) driven by a cycle-level bus master, checked against a
// transaction-level memory/handshake model.
module tb_pci_target_burst;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'hFFFF_FFC0;

    localparam int M_IDLE = 0;
    localparam int M_PRE  = 1;
    localparam int M_DATA = 2;
    localparam int M_STOP = 3;
    localparam int M_TURN = 4;

    logic        clk;
    logic        rst_n;
    logic        nframe;
    logic        nired;
    logic [3:0]  c_be;
    logic        ad_oe;
    logic [31:0] ad_drv;
    bit          sel;

    wire  [31:0] ad0;
    wire  [31:0] ad1;
    logic        nframe0, nframe1;
    logic        ntred0, ndevsel0, nstop0;
    logic        ntred1, ndevsel1, nstop1;
    wire  [2:0]  obs_ctl = sel ? {ntred1, ndevsel1, nstop1} : {ntred0, ndevsel0, nstop0};
    wire  [31:0] obs_ad  = sel ? ad1 : ad0;

    int          n_cmp;
    int          n_err;
    logic [31:0] mem_m [2][DEPTH];
    logic [31:0] wdata [64];
    logic [3:0]  wbe   [64];

    assign nframe0 = sel ? 1'b1 : nframe;
    assign nframe1 = sel ? nframe : 1'b1;
    assign ad0 = (ad_oe && !sel) ? ad_drv : 32'bz;
    assign ad1 = (ad_oe &&  sel) ? ad_drv : 32'bz;

    pci_target_burst u_dut0 (
        .clk          (clk),
        .reset        (rst_n),
        .Address_Data (ad0),
        .C_BE         (c_be),
        .NFRAME       (nframe0),
        .NIRED        (nired),
        .NTRED        (ntred0),
        .NDEVSEL      (ndevsel0),
        .NSTOP        (nstop0)
    );

    pci_target_burst #(
        .WAIT_STATES (3),
        .BURST_MAX   (2)
    ) u_dut1 (
        .clk          (clk),
        .reset        (rst_n),
        .Address_Data (ad1),
        .C_BE         (c_be),
        .NFRAME       (nframe1),
        .NIRED        (nired),
        .NTRED        (ntred1),
        .NDEVSEL      (ndevsel1),
        .NSTOP        (nstop1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input bit s);
        return s ? 3 : 1;
    endfunction

    function automatic int bm_of(input bit s);
        return s ? 2 : 0;
    endfunction

    task automatic bus_idle();
        nframe = 1'b1;
        nired  = 1'b1;
        ad_oe  = 1'b0;
        c_be   = 4'h0;
    endtask

    // One master transaction with nph data phases; wdata/wbe supply write phases.
    task automatic do_txn(input bit s, input logic [31:0] addr, input logic [3:0] cmd,
                          input int nph, input bit waits, input string tag);
        bit         hit, is_wr, fin;
        int         w, stop_at, idx0, done, p, edges, hold, mst, ph;
        logic [2:0] exp_ctl;
        sel     = s;
        is_wr   = (cmd == 4'b0111);
        hit     = ((cmd == 4'b0110) || (cmd == 4'b0111)) &&
                  ({1'b0, addr} >= 33'(BASE)) && ({1'b0, addr} < 33'(BASE) + 33'(4 * DEPTH));
        idx0    = hit ? int'((addr - BASE) >> 2) : 0;
        w       = is_wr ? ws_of(s) : ((ws_of(s) == 0) ? 1 : ws_of(s));
        stop_at = DEPTH - idx0;
        if (bm_of(s) != 0 && bm_of(s) < stop_at) stop_at = bm_of(s);
        @(negedge clk);
        nframe = 1'b0; ad_oe = 1'b1; ad_drv = addr; c_be = cmd; nired = 1'b1;
        mst   = hit ? ((w == 0) ? M_DATA : M_PRE) : M_IDLE;
        edges = 0; done = 0; p = 0; fin = 1'b0;
        hold  = int'($urandom_range(0, 2));
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            @(negedge clk);
            exp_ctl[2] = (mst == M_DATA) ? 1'b0 : 1'b1;
            exp_ctl[1] = (mst == M_PRE || mst == M_DATA || mst == M_STOP) ? 1'b0 : 1'b1;
            exp_ctl[0] = (mst == M_STOP || (mst == M_DATA && done + 1 == stop_at)) ? 1'b0 : 1'b1;
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin
                n_err++;
                $display("FAIL %s ctl cyc=%0d: {NTRED,NDEVSEL,NSTOP} got %b expected %b",
                         tag, cyc, obs_ctl, exp_ctl);
            end
            if (!is_wr && mst == M_DATA) begin
                n_cmp++;
                if (obs_ad !== mem_m[s][idx0 + done]) begin
                    n_err++;
                    $display("FAIL %s rdata idx=%0d: got %h expected %h",
                             tag, idx0 + done, obs_ad, mem_m[s][idx0 + done]);
                end
            end
            if ((hit && mst == M_IDLE) || (!hit && cyc >= nph + 1)) begin
                fin = 1'b1;
                bus_idle();
            end else begin
                if (mst == M_PRE || mst == M_DATA || !hit) begin
                    ph = hit ? p : cyc;
                    if (ph > nph - 1) ph = nph - 1;
                    nframe = (ph >= nph - 1);
                    nired  = (ph >= nph - 1 || !waits) ? 1'b0 : 1'($urandom_range(0, 1));
                    if (is_wr) begin
                        ad_oe = 1'b1; ad_drv = wdata[ph]; c_be = wbe[ph];
                    end else begin
                        ad_oe = 1'b0; c_be = 4'h0;
                    end
                end else if (mst == M_STOP) begin
                    nired = 1'b1; ad_oe = 1'b0;
                    if (hold > 0) begin
                        nframe = 1'b0; hold--;
                    end else begin
                        nframe = 1'b1;
                    end
                end else begin
                    bus_idle();
                end
                // Expected target state after the coming edge.
                case (mst)
                    M_PRE: begin
                        edges++;
                        if (edges == w) mst = M_DATA;
                    end
                    M_DATA: begin
                        if (!nired) begin
                            if (is_wr) begin
                                for (int i = 0; i < 4; i++)
                                    if (!c_be[i]) mem_m[s][idx0 + done][8*i +: 8] = ad_drv[8*i +: 8];
                            end
                            done++;
                            p++;
                            if (nframe) mst = M_TURN;
                            else if (done == stop_at) mst = M_STOP;
                        end
                    end
                    M_STOP:  if (nframe) mst = M_TURN;
                    M_TURN:  mst = M_IDLE;
                    default: mst = M_IDLE;
                endcase
            end
        end
        if (!fin) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: transaction did not end, state %0d expected %0d",
                     tag, mst, M_IDLE);
            bus_idle();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({ntred0, ndevsel0, nstop0, ntred1, ndevsel1, nstop1} !== 6'b111111) begin
            n_err++;
            $display("FAIL reset outputs: got %b expected 111111",
                     {ntred0, ndevsel0, nstop0, ntred1, ndevsel1, nstop1});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_preload();
        for (int i = 0; i < DEPTH; i++) begin
            wdata[i] = $urandom; wbe[i] = 4'h0;
        end
        do_txn(1'b0, BASE, 4'b0111, DEPTH, 1'b1, "preload0");
        for (int k = 0; k < DEPTH / 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                wdata[i] = $urandom; wbe[i] = 4'h0;
            end
            do_txn(1'b1, BASE + 32'(8 * k), 4'b0111, 3, 1'b1, "preload1");
        end
    endtask

    task automatic test_write_default();
        wdata[0] = 32'hFFFF_AAAA; wbe[0] = 4'b0000;
        do_txn(1'b0, 32'hFFFF_FFF4, 4'b0111, 1, 1'b0, "wr_default");
        do_txn(1'b0, 32'hFFFF_FFF4, 4'b0110, 1, 1'b0, "rd_default");
    endtask

    task automatic test_byte_enables();
        wdata[0] = 32'h0; wbe[0] = 4'b0000;
        do_txn(1'b0, 32'hFFFF_FFF4, 4'b0111, 1, 1'b0, "be_clear");
        wdata[0] = 32'h1234_5678; wbe[0] = 4'b0011;
        do_txn(1'b0, 32'hFFFF_FFF4, 4'b0111, 1, 1'b0, "be_write");
        do_txn(1'b0, 32'hFFFF_FFF4, 4'b0110, 1, 1'b0, "be_read");
    endtask

    task automatic test_window_end();
        for (int i = 0; i < 5; i++) begin
            wdata[i] = $urandom; wbe[i] = 4'h0;
        end
        do_txn(1'b0, 32'hFFFF_FFF4, 4'b0111, 5, 1'b0, "win_end_wr");
        do_txn(1'b0, 32'hFFFF_FFF0, 4'b0110, 6, 1'b1, "win_end_rd");
    endtask

    task automatic test_burst_max();
        do_txn(1'b1, BASE, 4'b0110, 4, 1'b0, "bmax_rd");
        do_txn(1'b1, BASE + 32'd4, 4'b0110, 5, 1'b1, "bmax_rd_w");
    endtask

    task automatic test_miss();
        wdata[0] = 32'hDEAD_BEEF; wbe[0] = 4'h0;
        wdata[1] = 32'hCAFE_F00D; wbe[1] = 4'h0;
        do_txn(1'b0, 32'h0000_0000, 4'b0111, 2, 1'b0, "miss_addr");
        do_txn(1'b0, BASE, 4'b0010, 2, 1'b0, "miss_cmd");
        do_txn(1'b1, 32'hFFFF_FF80, 4'b0111, 2, 1'b0, "miss_below");
        do_txn(1'b0, BASE, 4'b0110, 2, 1'b0, "miss_check");
    endtask

    task automatic test_reset_mid();
        logic [31:0] d0;
        logic [2:0]  exp_seq [6];
        exp_seq[0] = 3'b101; exp_seq[1] = 3'b001; exp_seq[2] = 3'b001;
        exp_seq[3] = 3'b111; exp_seq[4] = 3'b111; exp_seq[5] = 3'b111;
        sel = 1'b0;
        d0  = $urandom;
        @(negedge clk);
        nframe = 1'b0; ad_oe = 1'b1; ad_drv = 32'hFFFF_FFC8; c_be = 4'b0111; nired = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (obs_ctl !== exp_seq[c]) begin
                n_err++;
                $display("FAIL rst_mid ctl c=%0d: got %b expected %b", c, obs_ctl, exp_seq[c]);
            end
            case (c)
                0: begin ad_drv = d0; c_be = 4'h0; nired = 1'b0; end
                1: ;
                2: begin mem_m[0][2] = d0; ad_drv = $urandom; rst_n = 1'b0; end
                3: begin rst_n = 1'b1; ad_drv = $urandom; end
                4: nframe = 1'b1;
                default: bus_idle();
            endcase
        end
        do_txn(1'b0, 32'hFFFF_FFC8, 4'b0110, 2, 1'b0, "rst_mid_rd");
    endtask

    task automatic test_random();
        bit          s;
        int          nph;
        logic [31:0] addr;
        logic [3:0]  cmd;
        for (int t = 0; t < 24; t++) begin
            s    = 1'($urandom_range(0, 1));
            nph  = int'($urandom_range(1, 6));
            addr = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            cmd  = $urandom_range(0, 1) ? 4'b0111 : 4'b0110;
            for (int i = 0; i < nph; i++) begin
                wdata[i] = $urandom; wbe[i] = 4'($urandom);
            end
            do_txn(s, addr, cmd, nph, 1'b1, "random");
        end
    endtask

    task automatic test_readback_all();
        do_txn(1'b0, BASE, 4'b0110, DEPTH, 1'b1, "readback0");
        for (int k = 0; k < DEPTH / 2; k++)
            do_txn(1'b1, BASE + 32'(8 * k), 4'b0110, int'($urandom_range(2, 4)), 1'b1, "readback1");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < DEPTH; i++) mem_m[s][i] = 32'h0;
        test_reset();
        test_preload();
        test_write_default();
        test_byte_enables();
        test_window_end();
        test_burst_max();
        test_miss();
        test_reset_mid();
        test_random();
        test_readback_all();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
